// File: rtl/seven_segment_display_pkg.sv
// rtl/seven_segment_display_pkg.sv - segment codes, FSM states and digit decode for the 7-segment display stage
package seven_segment_display_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_COMMIT  = 2'd2
  } state_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seven_segment_display_bin2bcd_seq.sv
// rtl/seven_segment_display_bin2bcd_seq.sv - sequential shift-add-3 binary to BCD converter
module bin2bcd_seq
  import seven_segment_display_pkg::*;
#(
  parameter int COUNT_WIDTH = 7
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] bin,
  output logic                   done,
  output logic [3:0]             tens,
  output logic [3:0]             units,
  output logic [3:0]             hundreds
);

  localparam int SW = $clog2(COUNT_WIDTH + 1);

  logic [COUNT_WIDTH-1:0] sh;
  logic [11:0]            bcd;
  logic [11:0]            adj;
  logic [SW-1:0]          steps;
  logic                   active;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_comb begin
    adj = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
  end

  // done marks the edge that performs the final step; results are valid right after it
  assign done     = active && (steps == SW'(1));
  assign hundreds = bcd[11:8];
  assign tens     = bcd[7:4];
  assign units    = bcd[3:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh     <= '0;
      bcd    <= '0;
      steps  <= '0;
      active <= 1'b0;
    end else if (start) begin
      sh     <= bin;
      bcd    <= '0;
      steps  <= SW'(COUNT_WIDTH);
      active <= 1'b1;
    end else if (active) begin
      {bcd, sh} <= {adj, sh} << 1;
      steps     <= steps - SW'(1);
      if (steps == SW'(1)) active <= 1'b0;
    end
  end

endmodule

// File: rtl/seven_segment_display.sv
// rtl/seven_segment_display.sv - captures a count, converts to BCD and multiplexes two digits onto a 7-segment bus
module seven_segment_display
  import seven_segment_display_pkg::*;
#(
  parameter int COUNT_WIDTH  = 7,
  parameter int DIGIT_PERIOD = 1000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load,
  input  logic [COUNT_WIDTH-1:0] value,
  output logic [6:0]             segments,
  output logic                   digit,
  output logic                   busy,
  output logic                   overflow
);

  localparam int CW = $clog2(DIGIT_PERIOD);
  localparam logic [COUNT_WIDTH-1:0] MAX_SHOWN = COUNT_WIDTH'(99);

  state_t                 state;
  logic                   pend_valid;
  logic [COUNT_WIDTH-1:0] pend_val;
  logic                   conv_ovf;
  logic [3:0]             disp_tens;
  logic [3:0]             disp_units;
  logic                   blank;
  logic                   conv_start;
  logic [COUNT_WIDTH-1:0] conv_bin;
  logic                   conv_done;
  logic [3:0]             bcd_tens;
  logic [3:0]             bcd_units;
  logic [3:0]             bcd_hundreds;
  logic [CW-1:0]          mux_cnt;
  logic                   mux_wrap;
  logic                   next_digit;
  logic [6:0]             seg_next;

  // A load arriving on the commit edge wins over an older pending value
  always_comb begin
    conv_start = 1'b0;
    conv_bin   = value;
    if (state == ST_IDLE && load) begin
      conv_start = 1'b1;
    end else if (state == ST_COMMIT && (load || pend_valid)) begin
      conv_start = 1'b1;
      conv_bin   = load ? value : pend_val;
    end
  end

  bin2bcd_seq #(.COUNT_WIDTH(COUNT_WIDTH)) u_bin2bcd (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (conv_start),
    .bin      (conv_bin),
    .done     (conv_done),
    .tens     (bcd_tens),
    .units    (bcd_units),
    .hundreds (bcd_hundreds)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      pend_valid <= 1'b0;
      pend_val   <= '0;
      conv_ovf   <= 1'b0;
      disp_tens  <= '0;
      disp_units <= '0;
      overflow   <= 1'b0;
      blank      <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            state    <= ST_CONVERT;
            busy     <= 1'b1;
            conv_ovf <= value > MAX_SHOWN;
          end
        end
        ST_CONVERT: begin
          if (load) begin
            pend_valid <= 1'b1;
            pend_val   <= value;
          end
          if (conv_done) state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          disp_tens  <= bcd_tens;
          disp_units <= bcd_units;
          overflow   <= conv_ovf || (bcd_hundreds != 4'd0);
          blank      <= 1'b0;
          pend_valid <= 1'b0;
          if (conv_start) begin
            state    <= ST_CONVERT;
            conv_ovf <= conv_bin > MAX_SHOWN;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mux_wrap   = (mux_cnt == CW'(DIGIT_PERIOD - 1));
  assign next_digit = digit ^ mux_wrap;

  // Segments are decoded for the digit that becomes active on this same edge
  always_comb begin
    if (blank)         seg_next = SEG_BLANK;
    else if (overflow) seg_next = SEG_DASH;
    else               seg_next = seg_decode(next_digit ? disp_tens : disp_units);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mux_cnt  <= '0;
      digit    <= 1'b0;
      segments <= SEG_BLANK;
    end else begin
      mux_cnt  <= mux_wrap ? '0 : mux_cnt + CW'(1);
      digit    <= next_digit;
      segments <= seg_next;
    end
  end

endmodule
